// File: rtl/channel_pkg.sv
// Shared constants and helpers for the programmable ISI channel model.
// Q-format unity, accumulator sizing, noise LFSR polynomial and seed.
package channel_pkg;

  // Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting form).
  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic int unity(input int frac);
    return 1 << frac;
  endfunction

  // Sum of NUM_TAPS full-precision products plus rounding never overflows.
  function automatic int acc_width(input int r, input int cw, input int n);
    return r + cw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/isi_channel_prog_if.sv
// Sample, coefficient-write, noise-control and status bundle of the channel.
// master drives samples/controls and observes output; slave is the channel.
interface isi_channel_prog_if #(
  parameter int NUM_TAPS          = 8,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int COEF_WIDTH        = 10
);
  localparam int AW = $clog2(NUM_TAPS);

  logic signed [SIGNAL_RESOLUTION-1:0] signal_in;
  logic                                signal_in_valid;
  logic                                coef_wr_en;
  logic        [AW-1:0]                coef_wr_addr;
  logic signed [COEF_WIDTH-1:0]        coef_wr_data;
  logic                                noise_en;
  logic        [3:0]                   noise_shift;
  logic                                sat_clr;
  logic signed [SIGNAL_RESOLUTION-1:0] signal_out;
  logic                                signal_out_valid;
  logic                                sat_pulse;
  logic                                sat_sticky;

  modport master (
    output signal_in, signal_in_valid,
    output coef_wr_en, coef_wr_addr, coef_wr_data,
    output noise_en, noise_shift, sat_clr,
    input  signal_out, signal_out_valid,
    input  sat_pulse, sat_sticky
  );

  modport slave (
    input  signal_in, signal_in_valid,
    input  coef_wr_en, coef_wr_addr, coef_wr_data,
    input  noise_en, noise_shift, sat_clr,
    output signal_out, signal_out_valid,
    output sat_pulse, sat_sticky
  );
endinterface

// File: rtl/galois_lfsr.sv
// Right-shifting Galois LFSR that steps only when adv is high.
// Ports: clk, rst (sync, active-high, loads SEED), adv, state.
module galois_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [WIDTH-1:0] state
);
  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (adv)
      state_d = (state_q >> 1) ^ (state_q[0] ? POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;
endmodule

// File: rtl/isi_channel_prog.sv
// Programmable-tap ISI channel: delay line, registered products, round,
// optional LFSR noise, saturate. Ports: clk, rst, bus (slave).
module isi_channel_prog
  import channel_pkg::*;
#(
  parameter int          NUM_TAPS          = 8,
  parameter int          SIGNAL_RESOLUTION = 8,
  parameter int          COEF_WIDTH        = 10,
  parameter int          COEF_FRAC         = 8,
  parameter logic [15:0] LFSR_SEED         = LFSR_SEED_DEF
) (
  input logic               clk,
  input logic               rst,
  isi_channel_prog_if.slave bus
);
  localparam int R    = SIGNAL_RESOLUTION;
  localparam int PW   = SIGNAL_RESOLUTION + COEF_WIDTH;
  localparam int ACCW = acc_width(R, COEF_WIDTH, NUM_TAPS);

  localparam logic signed [COEF_WIDTH-1:0] ONE =
    COEF_WIDTH'(unity(COEF_FRAC));
  localparam logic signed [ACCW-1:0] RND  = ACCW'(unity(COEF_FRAC - 1));
  localparam logic signed [ACCW-1:0] MAXV = ACCW'(unity(R - 1) - 1);
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;

  logic signed [R-1:0]          x_q    [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic signed [PW-1:0]         p_q    [NUM_TAPS];
  logic                         v0_q, v1_q;
  logic signed [R-1:0]          out_q;
  logic                         ovld_q, pulse_q, sticky_q;

  logic [15:0]           lfsr;
  logic                  unused_lfsr_hi;
  logic signed [ACCW-1:0] acc_d, y_d;
  logic signed [R-1:0]   nz_d, out_d;
  logic                  hi_d, lo_d;

  galois_lfsr #(
    .WIDTH (16),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (v1_q),
    .state (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:R];

  always_comb begin
    acc_d = RND;
    for (int k = 0; k < NUM_TAPS; k++)
      acc_d = acc_d + ACCW'(p_q[k]);
    y_d  = acc_d >>> COEF_FRAC;
    nz_d = $signed(lfsr[R-1:0]) >>> bus.noise_shift;
    if (bus.noise_en)
      y_d = y_d + ACCW'(nz_d);
    hi_d  = y_d > MAXV;
    lo_d  = y_d < MINV;
    out_d = y_d[R-1:0];
    if (hi_d) out_d = MAXV[R-1:0];
    if (lo_d) out_d = MINV[R-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= (k == 0) ? ONE : '0;
        p_q[k]    <= '0;
      end
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      out_q    <= '0;
      ovld_q   <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      // Bubbles hold the delay line rather than shifting in zeros.
      if (bus.signal_in_valid) begin
        x_q[0] <= bus.signal_in;
        for (int k = 1; k < NUM_TAPS; k++)
          x_q[k] <= x_q[k-1];
      end
      v0_q <= bus.signal_in_valid;

      // Products see coef_q from before any write on this same edge.
      if (v0_q)
        for (int k = 0; k < NUM_TAPS; k++)
          p_q[k] <= PW'(x_q[k]) * PW'(coef_q[k]);
      v1_q <= v0_q;

      if (bus.coef_wr_en && (int'(bus.coef_wr_addr) < NUM_TAPS))
        coef_q[bus.coef_wr_addr] <= bus.coef_wr_data;

      ovld_q  <= v1_q;
      pulse_q <= v1_q && (hi_d || lo_d);
      if (v1_q)
        out_q <= out_d;

      // A clamp on the clearing edge wins over the clear.
      if (v1_q && (hi_d || lo_d)) sticky_q <= 1'b1;
      else if (bus.sat_clr)       sticky_q <= 1'b0;
    end
  end

  assign bus.signal_out       = out_q;
  assign bus.signal_out_valid = ovld_q;
  assign bus.sat_pulse        = pulse_q;
  assign bus.sat_sticky       = sticky_q;
endmodule

// File: tb/tb_isi_channel_prog.sv
// Directed bench for isi_channel_prog with hand-computed expectations.
// Immediate assertions at every comparison; one summary line at the end.
module tb_isi_channel_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   din  [16];
  int   dexp [16];
  int   dsat [16];

  isi_channel_prog_if #(
    .NUM_TAPS(8), .SIGNAL_RESOLUTION(8), .COEF_WIDTH(10)
  ) bus ();

  isi_channel_prog dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 3'(a);
    bus.coef_wr_data = 10'(d);
    step();
    bus.coef_wr_en   = 1'b0;
  endtask

  // Sends din[0..n-1] with gap idle cycles between samples; output of the
  // sample sent on edge k must appear (valid) right after edge k+2.
  task automatic run(input string tag, input int n, input int gap);
    int sent = 0;
    int idle = 0;
    int budget = 0;
    bit av = 0, bv = 0, nv;
    int ad = 0, bd = 0, as_ = 0, bs = 0, nd, ns;
    while ((sent < n || av || bv) && budget < 200) begin
      nv = 0; nd = 0; ns = 0;
      if (sent < n && idle == 0) begin
        bus.signal_in       = 8'(din[sent]);
        bus.signal_in_valid = 1'b1;
        nv = 1; nd = dexp[sent]; ns = dsat[sent];
        sent++;
        idle = gap;
      end else begin
        bus.signal_in_valid = 1'b0;
        if (idle > 0) idle--;
      end
      step();
      chk({tag, ".valid"}, bus.signal_out_valid, bv);
      if (bv) begin
        chk({tag, ".data"}, bus.signal_out, bd);
        chk({tag, ".sat"}, bus.sat_pulse, bs);
      end
      bv = av; bd = ad; bs = as_;
      av = nv; ad = nd; as_ = ns;
      budget++;
    end
    bus.signal_in_valid = 1'b0;
    if (budget >= 200) chk({tag, ".budget"}, budget, 0);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    logic [7:0]  lo;
    bus.signal_in       = '0;
    bus.signal_in_valid = 1'b0;
    bus.coef_wr_en      = 1'b0;
    bus.coef_wr_addr    = '0;
    bus.coef_wr_data    = '0;
    bus.noise_en        = 1'b0;
    bus.noise_shift     = '0;
    bus.sat_clr         = 1'b0;
    do_reset();

    chk("rst.out", bus.signal_out, 0);
    chk("rst.valid", bus.signal_out_valid, 0);
    chk("rst.pulse", bus.sat_pulse, 0);
    chk("rst.sticky", bus.sat_sticky, 0);

    // Identity channel, back-to-back.
    din[0] = 16;  dexp[0] = 16;  dsat[0] = 0;
    din[1] = -48; dexp[1] = -48; dsat[1] = 0;
    run("ident", 2, 0);

    // h = [1, 0.5], back-to-back then with 3-cycle gaps.
    din[0] = 48; dexp[0] = 48; dsat[0] = 0;
    din[1] = 0;  dexp[1] = 24; dsat[1] = 0;
    din[2] = 0;  dexp[2] = 0;  dsat[2] = 0;
    do_reset();
    wr(1, 128);
    run("h2", 3, 0);
    do_reset();
    wr(1, 128);
    run("h2gap", 3, 3);

    // Round half up with coef0 = 0.5.
    do_reset();
    wr(0, 128);
    din[0] = 1;  dexp[0] = 1; dsat[0] = 0;
    din[1] = -1; dexp[1] = 0; dsat[1] = 0;
    din[2] = 3;  dexp[2] = 2; dsat[2] = 0;
    run("round", 3, 0);

    // Saturation with h = [1, 1].
    do_reset();
    wr(1, 256);
    din[0] = 100;  dexp[0] = 100;  dsat[0] = 0;
    din[1] = 100;  dexp[1] = 127;  dsat[1] = 1;
    din[2] = -100; dexp[2] = 0;    dsat[2] = 0;
    din[3] = -100; dexp[3] = -128; dsat[3] = 1;
    run("sat", 4, 0);
    chk("sat.sticky", bus.sat_sticky, 1);
    bus.sat_clr = 1'b1;
    step();
    bus.sat_clr = 1'b0;
    chk("sat.clr", bus.sat_sticky, 0);
    bus.signal_in       = -8'sd100;
    bus.signal_in_valid = 1'b1;
    step();
    bus.signal_in_valid = 1'b0;
    step();
    bus.sat_clr = 1'b1;
    step();
    bus.sat_clr = 1'b0;
    chk("satclr.out", bus.signal_out, -128);
    chk("satclr.pulse", bus.sat_pulse, 1);
    chk("satclr.sticky", bus.sat_sticky, 1);

    // Coefficient written on a sample's product edge does not touch it.
    do_reset();
    bus.signal_in       = 8'sd20;
    bus.signal_in_valid = 1'b1;
    step();
    bus.signal_in_valid = 1'b0;
    wr(0, 128);
    step();
    chk("wrrace.valid", bus.signal_out_valid, 1);
    chk("wrrace.out", bus.signal_out, 20);
    din[0] = 20; dexp[0] = 10; dsat[0] = 0;
    run("wrnew", 1, 0);

    // Noise only, shift 0: reference Galois sequence from 16'hACE1.
    do_reset();
    bus.noise_en    = 1'b1;
    bus.noise_shift = 4'd0;
    s = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      lo = s[7:0];
      din[i]  = 0;
      dexp[i] = int'($signed(lo));
      dsat[i] = 0;
      s = lfsr_next(s);
    end
    run("noise0", 16, 0);

    // Shift 15: low bytes E1, 70, 38, 9C reduce to their sign.
    do_reset();
    bus.noise_shift = 4'd15;
    din[0] = 0; dexp[0] = -1; dsat[0] = 0;
    din[1] = 0; dexp[1] = 0;  dsat[1] = 0;
    din[2] = 0; dexp[2] = 0;  dsat[2] = 0;
    din[3] = 0; dexp[3] = -1; dsat[3] = 0;
    run("noise15", 4, 0);
    bus.noise_en    = 1'b0;
    bus.noise_shift = 4'd0;

    // Reset with a sample in the product stage.
    do_reset();
    wr(0, 128);
    din[0] = 50; dexp[0] = 25; dsat[0] = 0;
    run("prerst", 1, 0);
    bus.signal_in       = 8'sd60;
    bus.signal_in_valid = 1'b1;
    step();
    bus.signal_in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("midrst.valid", bus.signal_out_valid, 0);
    chk("midrst.out", bus.signal_out, 0);
    chk("midrst.pulse", bus.sat_pulse, 0);
    rst = 1'b0;
    step();
    chk("midrst.after", bus.signal_out_valid, 0);
    din[0] = 40; dexp[0] = 40; dsat[0] = 0;
    run("postrst", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/isi_channel_prog.md
Name: isi_channel_prog

Overview:
Parametrised, programmable-tap ISI channel model for the PAM-4 TX simulation path. It sits after symbol_to_signal and before the RX equaliser. The block convolves the baud-rate signed signal with a runtime-loadable fixed-point pulse response, optionally adds deterministic LFSR noise, then rounds and saturates back to SIGNAL_RESOLUTION. It replaces the fixed-response channel with a two-stage pipelined MAC.

Parameters:
NUM_TAPS, 8, pulse-response length in UI (>=2)
SIGNAL_RESOLUTION, 8, signed bit width of signal_in / signal_out
COEF_WIDTH, 10, signed coefficient width
COEF_FRAC, 8, coefficient fraction bits (256 = 1.0)
LFSR_SEED, 16'hACE1, non-zero noise LFSR reset value

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
signal_in  in  SIGNAL_RESOLUTION (signed)  input sample
signal_in_valid  in  1  sample strobe
coef_wr_en  in  1  coefficient write strobe
coef_wr_addr  in  $clog2(NUM_TAPS)  tap index (0 = cursor)
coef_wr_data  in  COEF_WIDTH (signed)  coefficient value
noise_en  in  1  enable noise injection
noise_shift  in  4  noise attenuation (arithmetic right shift)
sat_clr  in  1  clear sticky saturation flag
signal_out  out  SIGNAL_RESOLUTION (signed)  channel output
signal_out_valid  out  1  output strobe
sat_pulse  out  1  this output sample was clamped
sat_sticky  out  1  any clamp since last rst/sat_clr

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: delay line = 0; coef[0] = 1<<COEF_FRAC, other coefs = 0 (identity channel); LFSR = LFSR_SEED; pipeline valids = 0. All outputs = 0. Reset mid-stream discards in-flight samples, and no valid is emitted for them.
- Stage 0 (edge E0, signal_in_valid=1): x[0] <= signal_in, x[k] <= x[k-1]. With valid=0 the delay line holds, so bubbles never insert zeros.
- Stage 1 (E0+1): p[k] <= x[k]*coef[k], full-precision signed products, registered.
- Stage 2 (E0+2): acc = sum p[k] + (1<<(COEF_FRAC-1)); y = acc >>> COEF_FRAC (round-half-up); if noise_en, y += $signed(lfsr[SIGNAL_RESOLUTION-1:0]) >>> noise_shift; clamp y to [-2^(R-1), 2^(R-1)-1]. Register signal_out, signal_out_valid=1, sat_pulse=clamped.
- Latency is exactly 2 edges. There is one output valid per input valid, in order, and back-to-back inputs give back-to-back outputs.
- Accumulator width is SIGNAL_RESOLUTION+COEF_WIDTH+$clog2(NUM_TAPS)+1, so no internal overflow can occur.
- When no output is produced, signal_out holds its last value and signal_out_valid and sat_pulse are 0.
- Coefficient write commits on its edge. Stage-1 products use coef values registered before that edge. A write on the same edge as a sample's stage-1 edge therefore does not affect that sample.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances only on edges producing an output, regardless of noise_en. The noise value uses pre-advance state.
- sat_sticky: set on any clamp, cleared by sat_clr. If set and clear occur on the same edge, set wins. rst clears it.
- Out-of-range coef_wr_addr (NUM_TAPS not a power of 2) is ignored.

Decomposition:
- Shared package channel_pkg holds: the Q-format unity constant function, the accumulator-width function, the LFSR polynomial/tap constant, and the default seed.
- One natural sub-module: galois_lfsr (WIDTH, POLY, SEED; ports clk, rst, adv, state).
- MAC and saturation stay in isi_channel_prog.

Test Plan:
- After rst, noise_en=0: inputs 16, -48 -> outputs 16, -48, each exactly 2 edges after its input; sat_pulse=0.
- Write coef0=256, coef1=128 (h=[1,0.5]); inputs 48,0,0 -> 48, 24, 0. With valid gaps of 3 idle cycles between inputs, the outputs are unchanged.
- Rounding: coef0=128; input 1 -> 1; input -1 -> 0; input 3 -> 2.
- Saturation, R=8, coef0=coef1=256: inputs 100,100 -> 100, 127 (sat_pulse=1, sat_sticky=1). Then -100,-100 -> -128. sat_clr clears sticky; sat_clr together with a clamp leaves sticky=1.
- Noise: noise_en=1, noise_shift=0, zero input -> output equals the sign-extended low 8 bits of the reference LFSR sequence from LFSR_SEED. noise_shift=15 -> noise is 0 or -1 only.
- Assert rst one cycle after an input with a sample in stage 1 -> no output valid, signal_out=0, and coefs return to identity.
